// File: rtl/ctrl_seq_pkg.sv
// Shared types for the control sequencer: instruction field positions,
// opcode and FSM state encodings, and the decoded-instruction bundle.
package ctrl_seq_pkg;

   localparam int INSTR_W   = 24;
   localparam int OP_HI     = 23;
   localparam int OP_LO     = 20;
   localparam int ALUCTL_HI = 19;
   localparam int ALUCTL_LO = 18;
   localparam int RSVD_HI   = 17;
   localparam int RSVD_LO   = 16;
   localparam int WA_HI     = 15;
   localparam int WA_LO     = 12;
   localparam int RA1_HI    = 11;
   localparam int RA1_LO    = 8;
   localparam int RA2_HI    = 7;
   localparam int RA2_LO    = 4;
   localparam int IMM_HI    = 7;
   localparam int IMM_LO    = 0;

   typedef enum logic [3:0] {
      OP_NOP    = 4'h0,
      OP_ALU_RR = 4'h1,
      OP_ALU_RI = 4'h2,
      OP_CMP    = 4'h3,
      OP_BZ     = 4'h4,
      OP_JMP    = 4'h5,
      OP_HALT   = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LATCH  = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALTED = 3'd4
   } state_e;

   typedef struct packed {
      logic [3:0] wa;
      logic [3:0] ra1;
      logic [3:0] ra2;
      logic [7:0] imm;
      logic [7:0] target;
      logic [1:0] aluctl;
      logic       alusrc;
      logic       write;
      logic       sets_z;
      logic       is_branch;
      logic       is_jump;
      logic       is_halt;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/seq_decoder.sv
// Combinational instruction decoder: splits an instruction word into
// datapath control fields and sequencing flags.
module seq_decoder
   import ctrl_seq_pkg::*;
(
   input  logic [INSTR_W-1:0] ir,
   output dec_t               dec
);

   logic unused_rsvd_s;
   assign unused_rsvd_s = ^ir[RSVD_HI:RSVD_LO];

   // Field extraction plus opcode classification
   always_comb begin
      dec        = '0;
      dec.wa     = ir[WA_HI:WA_LO];
      dec.ra1    = ir[RA1_HI:RA1_LO];
      dec.ra2    = ir[RA2_HI:RA2_LO];
      dec.aluctl = ir[ALUCTL_HI:ALUCTL_LO];
      dec.target = ir[IMM_HI:IMM_LO];
      case (ir[OP_HI:OP_LO])
         OP_NOP:    dec.illegal = 1'b0;
         OP_ALU_RR: begin
            dec.write  = 1'b1;
            dec.sets_z = 1'b1;
         end
         OP_ALU_RI: begin
            dec.alusrc = 1'b1;
            dec.imm    = ir[IMM_HI:IMM_LO];
            dec.write  = 1'b1;
            dec.sets_z = 1'b1;
         end
         OP_CMP:    dec.sets_z    = 1'b1;
         OP_BZ:     dec.is_branch = 1'b1;
         OP_JMP:    dec.is_jump   = 1'b1;
         OP_HALT:   dec.is_halt   = 1'b1;
         default:   dec.illegal   = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Three-cycle FETCH/LATCH/EXEC instruction sequencer driving the register-file/ALU
// datapath. Define CTRL_SEQ_ILLEGAL_TRAP_EN to halt with err on illegal opcodes.
module ctrl_sequencer
   import ctrl_seq_pkg::*;
#(
   parameter int PC_W = 8
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic [7:0]         alu_result,
   output logic [3:0]         RA1,
   output logic [3:0]         RA2,
   output logic [3:0]         WA,
   output logic [7:0]         external_data_in,
   output logic               RegWrite,
   output logic               ALUSrc,
   output logic [1:0]         ALUControl,
   output logic               busy,
   output logic               halted,
   output logic               err
);

   state_e             state_r;
   logic [PC_W-1:0]    pc_r;
   logic [INSTR_W-1:0] ir_r;
   logic               z_r;

   logic [INSTR_W-1:0] dec_in_s;
   dec_t               dec_s;
   logic [PC_W-1:0]    pc_inc_s;
   logic [PC_W-1:0]    pc_tgt_s;
   logic [PC_W-1:0]    pc_next_s;
   logic               trap_s;
   logic               unused_tgt_s;

   // During LATCH the ROM word is decoded directly so fields are valid in EXEC
   assign dec_in_s = (state_r == ST_LATCH) ? imem_data : ir_r;

   seq_decoder u_dec (
      .ir  (dec_in_s),
      .dec (dec_s)
   );

   assign pc_inc_s     = pc_r + PC_W'(1);
   assign pc_tgt_s     = dec_s.target[PC_W-1:0];
   assign unused_tgt_s = ^dec_s.target;

`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
   assign trap_s = dec_s.illegal;
`else
   logic unused_illegal_s;
   assign unused_illegal_s = dec_s.illegal;
   assign trap_s           = 1'b0;
`endif

   // Next program counter for the instruction in EXEC
   always_comb begin
      pc_next_s = pc_inc_s;
      if (dec_s.is_halt || trap_s) begin
         pc_next_s = pc_r;
      end else if (dec_s.is_jump || (dec_s.is_branch && z_r)) begin
         pc_next_s = pc_tgt_s;
      end else begin
         pc_next_s = pc_inc_s;
      end
   end

   // Sequencer FSM with all datapath controls registered
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r          <= ST_IDLE;
         pc_r             <= '0;
         ir_r             <= '0;
         z_r              <= 1'b0;
         imem_addr        <= '0;
         RA1              <= 4'h0;
         RA2              <= 4'h0;
         WA               <= 4'h0;
         external_data_in <= 8'h00;
         RegWrite         <= 1'b0;
         ALUSrc           <= 1'b0;
         ALUControl       <= 2'b00;
         busy             <= 1'b0;
         halted           <= 1'b0;
         err              <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_HALTED: begin
               if (start) begin
                  state_r   <= ST_FETCH;
                  pc_r      <= '0;
                  z_r       <= 1'b0;
                  err       <= 1'b0;
                  imem_addr <= '0;
                  busy      <= 1'b1;
                  halted    <= 1'b0;
               end else begin
                  state_r <= state_r;
               end
            end
            ST_FETCH: begin
               state_r <= ST_LATCH;
            end
            ST_LATCH: begin
               state_r          <= ST_EXEC;
               ir_r             <= imem_data;
               WA               <= dec_s.wa;
               RA1              <= dec_s.ra1;
               RA2              <= dec_s.ra2;
               external_data_in <= dec_s.imm;
               ALUSrc           <= dec_s.alusrc;
               ALUControl       <= dec_s.aluctl;
               RegWrite         <= dec_s.write;
            end
            ST_EXEC: begin
               RegWrite  <= 1'b0;
               pc_r      <= pc_next_s;
               imem_addr <= pc_next_s;
               if (dec_s.sets_z) begin
                  z_r <= (alu_result == 8'h00);
               end else begin
                  z_r <= z_r;
               end
               if (dec_s.is_halt || trap_s) begin
                  state_r <= ST_HALTED;
                  busy    <= 1'b0;
                  halted  <= 1'b1;
                  err     <= trap_s;
               end else begin
                  state_r <= ST_FETCH;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               busy     <= 1'b0;
               halted   <= 1'b0;
               RegWrite <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: an instruction-level reference model
// predicts each executed instruction; a monitor checks them as the DUT runs.
module tb_ctrl_sequencer;

`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   localparam int K_INSTR = 0;
   localparam int K_END   = 1;
   localparam int K_ABORT = 2;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  imem_addr;
   logic [23:0] imem_data;
   logic [7:0]  alu_result;
   logic [3:0]  RA1, RA2, WA;
   logic [7:0]  external_data_in;
   logic        RegWrite, ALUSrc;
   logic [1:0]  ALUControl;
   logic        busy, halted, err;

   logic        start2 = 1'b0;
   logic [1:0]  imem_addr2;
   logic [23:0] imem_data2;
   logic [3:0]  RA1_2, RA2_2, WA_2;
   logic [7:0]  ext_2;
   logic        RegWrite_2, ALUSrc_2;
   logic [1:0]  ALUControl_2;
   logic        busy2, halted2, err2;

   logic [23:0] rom [256];
   logic [7:0]  alu_vals [64];

   typedef struct {
      int kind;
      int pc;
      int wa, ra1, ra2, ext, rw, alusrc, aluctl, err;
   } rec_t;

   rec_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   pos = 0;
   bit   busy_prev = 1'b0;

   ctrl_sequencer #(.PC_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr),
      .imem_data(imem_data), .alu_result(alu_result), .RA1(RA1), .RA2(RA2),
      .WA(WA), .external_data_in(external_data_in), .RegWrite(RegWrite),
      .ALUSrc(ALUSrc), .ALUControl(ALUControl), .busy(busy), .halted(halted),
      .err(err)
   );

   ctrl_sequencer #(.PC_W(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .imem_addr(imem_addr2),
      .imem_data(imem_data2), .alu_result(alu_result), .RA1(RA1_2), .RA2(RA2_2),
      .WA(WA_2), .external_data_in(ext_2), .RegWrite(RegWrite_2),
      .ALUSrc(ALUSrc_2), .ALUControl(ALUControl_2), .busy(busy2), .halted(halted2),
      .err(err2)
   );

   assign imem_data2 = 24'h000000;

   always #5 clk = ~clk;

   // Synchronous-read instruction ROM
   always @(posedge clk) imem_data <= rom[imem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: walks the program instruction by instruction
   task automatic model(input int cap, output int n, output bit aborted);
      int pc = 0;
      int k = 0;
      bit z = 1'b0;
      bit ill, stop;
      int op;
      logic [23:0] ins;
      rec_t r;
      aborted = 1'b0;
      while (1) begin
         r = '{default: 0};
         r.pc = pc;
         if (k == cap - 1) begin
            r.kind = K_ABORT;
            q.push_back(r);
            aborted = 1'b1;
            k++;
            break;
         end
         ins      = rom[pc];
         op       = int'(ins[23:20]);
         r.kind   = K_INSTR;
         r.wa     = int'(ins[15:12]);
         r.ra1    = int'(ins[11:8]);
         r.ra2    = int'(ins[7:4]);
         r.aluctl = int'(ins[19:18]);
         r.alusrc = (op == 2) ? 1 : 0;
         r.ext    = (op == 2) ? int'(ins[7:0]) : 0;
         r.rw     = (op == 1 || op == 2) ? 1 : 0;
         q.push_back(r);
         ill  = !(op inside {[0:5], 15});
         if (op >= 1 && op <= 3) z = (alu_vals[k] == 8'h00);
         stop = (op == 15) || (TRAP && ill);
         k++;
         if (stop) begin
            r.kind = K_END;
            r.err  = (TRAP && ill) ? 1 : 0;
            q.push_back(r);
            break;
         end
         if (op == 5 || (op == 4 && z)) pc = int'(ins[7:0]);
         else pc = (pc + 1) % 256;
      end
      n = k;
   endtask

   task automatic run_prog(input int cap);
      int n, last, ign;
      bit ab;
      model(cap, n, ab);
      last = ab ? 3 * (n - 1) + 1 : 3 * n - 1;
      ign  = -1;
      if (ab && n > 1) ign = $urandom_range(3 * (n - 1), 1);
      if (!ab) ign = $urandom_range(3 * n - 2, 1);
      @(negedge clk);
      start = 1'b1;
      for (int c = 0; c <= last; c++) begin
         @(negedge clk);
         start      = (c == ign);
         alu_result = alu_vals[c / 3];
         if (ab && c == last) begin
            reset = 1'b0;
            #1;
            chk("rst_regwrite", RegWrite, 0);
            chk("rst_busy", busy, 0);
            chk("rst_addr", imem_addr, 0);
            chk("rst_wa", WA, 0);
            chk("rst_ra1", RA1, 0);
            chk("rst_ra2", RA2, 0);
            chk("rst_aluctl", ALUControl, 0);
            chk("rst_ext", external_data_in, 0);
         end
      end
      start = 1'b0;
      if (ab) begin
         repeat (2) @(negedge clk);
         reset = 1'b1;
      end
      repeat (3) @(negedge clk);
   endtask

   function automatic logic [23:0] rand_instr();
      logic [23:0] w;
      logic [3:0]  op;
      int sel;
      w   = 24'($urandom);
      sel = $urandom_range(15, 0);
      case (sel)
         0, 1:    op = 4'h0;
         2, 3, 4: op = 4'h1;
         5, 6:    op = 4'h2;
         7, 8:    op = 4'h3;
         9, 10:   op = 4'h4;
         11:      op = 4'h5;
         12:      op = 4'hF;
         13:      op = 4'($urandom_range(14, 6));
         default: op = 4'h1;
      endcase
      w[23:20] = op;
      if (op == 4'h4 || op == 4'h5) w[7:5] = 3'b000;
      return w;
   endfunction

   task automatic clear_rom(input logic [7:0] alu);
      for (int a = 0; a < 256; a++) rom[a] = 24'h000000;
      for (int a = 0; a < 64; a++) alu_vals[a] = alu;
   endtask

   // Monitor: follows busy phases and compares against queued expectations
   always @(posedge clk) begin
      rec_t r;
      #1;
      if (busy === 1'b1) begin
         if (q.size() == 0) begin
            chk("busy_without_expectation", busy, 0);
         end else begin
            r = q[0];
            if (pos == 0) begin
               chk("fetch_addr", imem_addr, r.pc);
               chk("halted_while_busy", halted, 0);
            end
            if (pos == 2) begin
               r = q.pop_front();
               chk("exec_kind", r.kind, K_INSTR);
               chk("exec_wa", WA, r.wa);
               chk("exec_ra1", RA1, r.ra1);
               chk("exec_ra2", RA2, r.ra2);
               chk("exec_ext", external_data_in, r.ext);
               chk("exec_alusrc", ALUSrc, r.alusrc);
               chk("exec_aluctl", ALUControl, r.aluctl);
               chk("exec_regwrite", RegWrite, r.rw);
               chk("exec_err", err, 0);
            end else begin
               chk("regwrite_outside_exec", RegWrite, 0);
            end
         end
         pos = (pos == 2) ? 0 : pos + 1;
      end else begin
         chk("regwrite_idle", RegWrite, 0);
         if (busy_prev) begin
            if (q.size() == 0) begin
               chk("end_without_expectation", busy_prev, 0);
            end else begin
               r = q.pop_front();
               if (r.kind == K_END) begin
                  chk("end_halted", halted, 1);
                  chk("end_err", err, r.err);
                  chk("end_pc", imem_addr, r.pc);
               end else if (r.kind == K_ABORT) begin
                  chk("abort_halted", halted, 0);
                  chk("abort_err", err, 0);
                  chk("abort_addr", imem_addr, 0);
                  chk("abort_wa", WA, 0);
               end else begin
                  chk("stop_kind", r.kind, K_END);
               end
            end
         end
         pos = 0;
      end
      busy_prev = busy;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      clear_rom(8'h00);
      alu_result = 8'h00;
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_halted", halted, 0);
      chk("reset_err", err, 0);
      chk("reset_regwrite", RegWrite, 0);
      chk("reset_addr", imem_addr, 0);
      chk("reset_wa", WA, 0);
      chk("reset_ext", external_data_in, 0);
      reset = 1'b1;

      // Narrow PC wraps 3 -> 0
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk("wrap2_addr", imem_addr2, k % 4);
         chk("wrap2_busy", busy2, 1);
         repeat (3) @(negedge clk);
      end

      clear_rom(8'h2A);
      rom[0] = 24'h201005;
      rom[1] = 24'hF4E7C5;
      run_prog(1000);

      clear_rom(8'h00);
      rom[0] = 24'h1C1230;
      run_prog(1);

      clear_rom(8'h00);
      rom[0] = 24'h300120;
      rom[1] = 24'h400009;
      rom[9] = 24'hF00000;
      run_prog(1000);

      clear_rom(8'h00);
      rom[0]   = 24'h400005;
      rom[1]   = 24'h300000;
      rom[2]   = 24'h5000FD;
      rom[5]   = 24'hF00000;
      run_prog(1000);

      clear_rom(8'h03);
      rom[0] = 24'h300120;
      rom[1] = 24'h400009;
      rom[2] = 24'hF00000;
      rom[9] = 24'hF00000;
      run_prog(1000);

      clear_rom(8'h00);
      rom[0] = 24'h500007;
      rom[7] = 24'hF00000;
      run_prog(1000);

      clear_rom(8'h00);
      rom[0] = 24'h700000;
      rom[1] = 24'hF00000;
      run_prog(1000);

      for (int t = 0; t < 25; t++) begin
         for (int a = 0; a < 256; a++) rom[a] = rand_instr();
         for (int a = 0; a < 64; a++) alu_vals[a] = ($urandom_range(2, 0) == 0) ? 8'h00 : 8'($urandom);
         run_prog(30);
      end

      repeat (4) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Multi-cycle instruction sequencer that sits directly upstream of the register-file/ALU datapath and drives all of its control inputs.
- Fetches 24-bit instructions from a synchronous-read instruction ROM and decodes them into read/write register addresses, ALU operation, operand select and immediate data.
- Takes the datapath's 8-bit ALU result back to form a zero flag for conditional branches.

Parameters:
- PC_W, 8, program-counter width. Legal range 1..8. Instruction memory depth is 2^PC_W.

Ports:
- clk  input  1  system clock. Single clock domain; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- start  input  1  pulse: begin execution at PC 0. Honoured only in IDLE or HALTED.
- imem_addr  output  PC_W  instruction ROM address.
- imem_data  input  24  ROM read data, valid one cycle after imem_addr.
- alu_result  input  8  ALU result fed back from the datapath.
- RA1, RA2, WA  output  4 each  register read/write addresses.
- external_data_in  output  8  immediate operand.
- RegWrite  output  1  register-file write enable.
- ALUSrc  output  1  0 = register operand B, 1 = immediate.
- ALUControl  output  2  ALU operation, passed through from the instruction.
- busy  output  1  high in FETCH, LATCH or EXEC.
- halted  output  1  high in HALTED.
- err  output  1  illegal-opcode trap flag (see Optional Feature).

Behaviour:
- Instruction fields:
  - op = [23:20]
  - aluctl = [19:18]
  - [17:16] reserved, ignored
  - WA = [15:12]
  - RA1 = [11:8]
  - RA2 = [7:4]
  - imm = [7:0] (overlaps RA2; target = imm[PC_W-1:0])
- Opcodes:
  - 0 NOP
  - 1 ALU_RR: ALUSrc=0, write WA
  - 2 ALU_RI: ALUSrc=1, external_data_in=imm, write WA
  - 3 CMP: like ALU_RR but no write
  - 4 BZ: PC=target if Z=1
  - 5 JMP: PC=target
  - F HALT
  - All other opcodes are illegal.
- Reset values: all outputs 0, PC=0, IR=0, Z=0, state IDLE.
- FSM states: IDLE, FETCH, LATCH, EXEC, HALTED.
  - IDLE: start -> FETCH, with PC=0 and Z=0.
  - FETCH: imem_addr=PC -> LATCH.
  - LATCH: IR<=imem_data -> EXEC.
  - EXEC: drive the decoded fields; update PC; -> FETCH, or -> HALTED on HALT.
  - HALTED: start -> FETCH, with PC=0, Z=0 and err cleared.
- Latency: exactly 3 cycles per instruction.
- Field outputs are registered from IR and stay stable from LATCH+1 through the next LATCH.
- RegWrite is high only during the EXEC cycle of ALU_RR/ALU_RI: exactly one cycle, written at the EXEC-ending edge.
- Z is set to (alu_result==0) at the EXEC-ending edge for ALU_RR, ALU_RI and CMP. All other opcodes leave Z unchanged.
- PC update:
  - Default: PC+1 modulo 2^PC_W (PC = 2^PC_W-1 wraps to 0).
  - Branch/jump target overrides the increment.
  - HALT holds PC.
- start while busy is ignored.
- reset asserted mid-instruction aborts it: no RegWrite pulse is emitted after reset asserts.

Optional Feature:
- Macro: CTRL_SEQ_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in EXEC forces RegWrite=0, sets err=1 and goes to HALTED with PC held at the offending address.
- Undefined: an illegal opcode executes as NOP; err is tied to 0.

Decomposition:
- Package ctrl_seq_pkg holds:
  - opcode enum (4-bit)
  - FSM state enum
  - field bit-position localparams
  - INSTR_W=24
- Natural sub-module: seq_decoder, combinational. Maps IR to WA/RA1/RA2/imm/ALUSrc/ALUControl/write/is_branch/is_jump/is_halt/illegal.

Test Plan:
- Reset release, start pulse, ROM[0]=0x201005 (ALU_RI, WA=1, RA1=0, imm=5) -> in EXEC (3rd cycle): WA=1, RA1=0, ALUSrc=1, external_data_in=0x05, RegWrite=1 for exactly one cycle. Next imem_addr=1.
- ROM: 0x300120 (CMP r1,r2) with stubbed alu_result=0, then 0x400009 (BZ 9) -> next fetch at imem_addr=9. Repeat with alu_result=0x03 -> next fetch at 2.
- ROM[0]=0x500007 (JMP 7), ROM[7]=0xF00000 (HALT) -> halted=1 after 6 cycles, busy=0, no RegWrite pulse. Then start -> fetch at 0 again.
- PC_W=2, ROM all NOP -> imem_addr sequence 0,1,2,3,0 (wrap).
- Assert reset during LATCH of an ALU_RR instruction -> all outputs 0 immediately, RegWrite never pulses, state IDLE.
- ROM[0]=0x700000 -> with CTRL_SEQ_ILLEGAL_TRAP_EN: err=1, halted=1, PC stays 0. Without it: behaves as NOP and fetches address 1.
